demultiplexor8: RTL
===================

DEMULTIPLEXOR8 -- requirements
Module: demultiplexor8

Interface
REQ-001 SHALL have parameter BITS, default 32, giving the data word width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port datoInput  input  BITS  word offered by the producer.
REQ-005 SHALL have port selDato  input  3  destination channel: 0=A, 1=B ... 7=H.
REQ-006 SHALL have port validInput  input  1  producer asserts that datoInput/selDato are valid.
REQ-007 SHALL have port readyInput  output  1  block can accept the offered word this cycle.
REQ-008 SHALL have ports datoA..datoH  output  BITS each  registered channel holding words.
REQ-009 SHALL have port validOutput  output  8  bit i: channel i holds an unconsumed word (bit 0=A ... bit 7=H).
REQ-010 SHALL have port readyOutput  input  8  bit i: consumer of channel i takes the word this cycle.
REQ-011 SHALL have port ocupados  output  4  number of channels with validOutput set, 0..8.

Function
REQ-012 SHALL hold one word per channel in a BITS-wide holding register with an associated valid flag driving validOutput[i].
REQ-013 SHALL drive readyInput = !validOutput[selDato] | readyOutput[selDato], combinationally, independent of validInput.
REQ-014 SHALL accept a word when validInput & readyInput at a rising edge: register[selDato] <= datoInput, validOutput[selDato] <= 1.
REQ-015 SHALL present an accepted word on its dato output and validOutput bit exactly 1 cycle after acceptance (no combinational path datoInput -> dato outputs).
REQ-016 SHALL consume channel i when validOutput[i] & readyOutput[i] at a rising edge: validOutput[i] <= 0 unless the same edge also accepts into channel i.
REQ-017 SHALL, on simultaneous accept and consume on the same channel, load the new word and keep validOutput[i]=1 (pass-through, no bubble).
REQ-018 SHALL allow one accept plus up to eight consumes (any channels) on the same edge.
REQ-019 SHALL ignore readyOutput[i] while validOutput[i]=0.
REQ-020 SHALL keep each holding register unchanged except on acceptance into that channel; after consumption the last word remains visible with validOutput[i]=0.
REQ-021 SHALL never overwrite a valid, unconsumed word; when validOutput[selDato]=1 and readyOutput[selDato]=0, readyInput=0 and validInput is ignored.
REQ-022 SHALL update ocupados registered, equal to the popcount of validOutput after each edge: +1 on accept into empty channel, -1 per consume without reload, net 0 on REQ-017 case.
REQ-023 SHALL not require validInput to be held; a producer withdrawing validInput while readyInput=0 causes no state change.
REQ-024 SHALL treat selDato changes while readyInput=0 as a new request evaluated against the new channel.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, clear all validOutput bits to 0, datoA..datoH to 0 and ocupados to 0, regardless of concurrent accept/consume.
REQ-026 SHALL drive readyInput=1 in the first cycle after reset (all channels empty).
REQ-027 SHALL discard in-flight words held at reset; no valid is asserted until a new acceptance after rst deasserts.

Verification
REQ-028 Reset then validInput=1, selDato=5, datoInput=0xDEADBEEF, readyOutput=0 -> next cycle datoF=0xDEADBEEF, validOutput=8'b0010_0000, ocupados=1; other channels 0.
REQ-029 Fill channels 0..7 with 0x10..0x17, readyOutput=0 -> ocupados=8; ninth offer to selDato=3 sees readyInput=0, datoD stays 0x13.
REQ-030 Channel 2 valid with 0xAAAA, offer 0x5555 to selDato=2 with readyOutput[2]=1 same cycle -> readyInput=1; next cycle datoC=0x5555, validOutput[2]=1, ocupados unchanged.
REQ-031 Channels 0,4,7 valid, readyOutput=8'b1001_0001 and accept into empty channel 1 same edge -> validOutput=8'b0000_0010, ocupados=1, datoA/E/H retain old words.
REQ-032 rst=1 asserted while validInput=1 and channels 0..3 valid -> next cycle validOutput=0, all dato outputs 0, ocupados=0, readyInput=1; offered word not captured.
REQ-033 Random accept/consume traffic over 10,000 cycles vs. scoreboard -> no lost, duplicated or overwritten word; ocupados always equals popcount(validOutput).

Source files
------------

// File: rtl/demultiplexor8.sv
// Eight-way demultiplexor with a one-word holding register per channel.
// Each channel has valid/ready handshaking, and the block keeps a registered count of occupied channels.
module demultiplexor8 #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] datoInput,
  input  logic [2:0]      selDato,
  input  logic            validInput,
  output logic            readyInput,
  output logic [BITS-1:0] datoA,
  output logic [BITS-1:0] datoB,
  output logic [BITS-1:0] datoC,
  output logic [BITS-1:0] datoD,
  output logic [BITS-1:0] datoE,
  output logic [BITS-1:0] datoF,
  output logic [BITS-1:0] datoG,
  output logic [BITS-1:0] datoH,
  output logic [7:0]      validOutput,
  input  logic [7:0]      readyOutput,
  output logic [3:0]      ocupados
);

  localparam int CHANNELS = 8;

  logic [BITS-1:0] data_word [CHANNELS];
  logic [7:0]      valid_reg;
  logic [7:0]      valid_next;
  logic [7:0]      load;
  logic [7:0]      consume;
  logic [3:0]      count_reg;
  logic [3:0]      count_next;
  logic            ready;
  logic            accept;

  // A full channel can still take a new word if its consumer drains it on the same edge.
  always_comb begin
    ready = !valid_reg[selDato] || readyOutput[selDato];
  end

  always_comb begin
    accept = validInput && ready;
    load = '0;
    if (accept) begin
      load[selDato] = 1'b1;
    end
    consume    = valid_reg & readyOutput;
    valid_next = (valid_reg & ~consume) | load;
    count_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count_next = count_next + 4'(valid_next[i]);
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [BITS-1:0] word_reg;

      // The word stays visible after it is consumed; only a new load replaces it.
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (load[gi]) begin
          word_reg <= datoInput;
        end
      end

      assign data_word[gi] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  assign readyInput  = ready;
  assign validOutput = valid_reg;
  assign ocupados    = count_reg;

  assign datoA = data_word[0];
  assign datoB = data_word[1];
  assign datoC = data_word[2];
  assign datoD = data_word[3];
  assign datoE = data_word[4];
  assign datoF = data_word[5];
  assign datoG = data_word[6];
  assign datoH = data_word[7];

endmodule
